seg_scan_controller: RTL

Time-multiplexed scan controller for a bank of common-segment seven-segment digits that share one decoder and one 7-bit segment bus. It holds a multi-digit BCD value and cycles through the digits, enabling one digit at a time. Each digit gets a dead-time blank to prevent ghosting. New values are committed only at frame boundaries, so no digit shows torn data. It sits between the value-producing logic and the display pins.

---
 rtl/seg_scan_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for a bank of seven-segment digits that
// share one segment bus. A value is staged in a shadow register and only
// becomes visible at a frame boundary (or when scanning starts), so a digit
// never shows a mix of old and new data. Each digit slot is a dead-time
// blank followed by a dwell with that digit's enable asserted.
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic                      lz_blank,
  output logic [6:0]                seg,
  output logic [NUM_DIGITS-1:0]     dig_en,
  output logic                      frame_done,
  output logic                      pending
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Sequential state
  state_t                    state_reg;
  logic [IDX_W-1:0]          idx_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic [4*NUM_DIGITS-1:0]   shadow_reg;
  logic [4*NUM_DIGITS-1:0]   active_reg;
  logic                      pending_reg;
  logic [6:0]                seg_reg;
  logic [NUM_DIGITS-1:0]     dig_en_reg;
  logic                      frame_done_reg;

  // Next-state values
  state_t                    state_next;
  logic [IDX_W-1:0]          idx_next;
  logic [CNT_W-1:0]          cnt_next;
  logic                      commit;
  logic [6:0]                seg_next;
  logic [NUM_DIGITS-1:0]     dig_en_next;
  logic                      frame_done_next;

  // Per-digit decoded segments and leading-zero blank flags
  logic [6:0]                digit_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]     nz_above;
  logic [NUM_DIGITS-1:0]     blanked;

  // BCD to {a,b,c,d,e,f,g}; codes 10-15 are dark.
  function automatic logic [6:0] decode_bcd(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // One decoder and one leading-zero test per digit, all fed from the
  // committed value so the shown data is stable for the whole frame.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_seg[gi] = decode_bcd(active_reg[4*gi +: 4]);
    assign nz_above[gi]  = |active_reg[4*NUM_DIGITS-1 : 4*gi];
    if (gi == 0) begin : g_lsd
      // The least significant digit always shows, even for an all-zero value.
      assign blanked[gi] = 1'b0;
    end else begin : g_upper
      assign blanked[gi] = lz_blank & ~nz_above[gi];
    end
  end

  // Next-state logic: slot sequencing, digit stepping and commit points.
  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;
    commit          = 1'b0;
    frame_done_next = 1'b0;
    if (!en) begin
      // Disabling abandons the frame: no completion pulse, no commit.
      state_next = IDLE;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = BLANK;
          idx_next   = '0;
          cnt_next   = '0;
          commit     = pending_reg;
        end
        BLANK: begin
          if (cnt_reg == BLANK_LAST) begin
            state_next = SHOW;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt_reg == DWELL_LAST) begin
            state_next = BLANK;
            cnt_next   = '0;
            if (idx_reg == IDX_LAST) begin
              idx_next        = '0;
              frame_done_next = 1'b1;
              commit          = pending_reg;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output values for the coming cycle, derived from the next state so the
  // registered pins line up with the state they belong to. SHOW is only
  // entered from BLANK, where no commit happens, so active_reg is current.
  always_comb begin
    seg_next    = 7'd0;
    dig_en_next = '0;
    if (state_next == SHOW) begin
      dig_en_next = NUM_DIGITS'(1) << idx_next;
      seg_next    = blanked[idx_next] ? 7'd0 : digit_seg[idx_next];
    end
  end

  // Scan state and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      seg_reg        <= 7'd0;
      dig_en_reg     <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      seg_reg        <= seg_next;
      dig_en_reg     <= dig_en_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Shadow/active value path. A load in the same cycle as a commit still
  // captures the new value and keeps it pending; the commit takes the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg  <= '0;
      active_reg  <= '0;
      pending_reg <= 1'b0;
    end else begin
      if (commit) begin
        active_reg <= shadow_reg;
      end
      if (load) begin
        shadow_reg  <= data_in;
        pending_reg <= 1'b1;
      end else if (commit) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign seg        = seg_reg;
  assign dig_en     = dig_en_reg;
  assign frame_done = frame_done_reg;
  assign pending    = pending_reg;

endmodule
